// File: rtl/game_launcher_pkg.sv
// rtl/game_launcher_pkg.sv - shared types for the sprite launcher
package game_launcher_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_XY,
    S_LOAD_DXY,
    S_RUN,
    S_REVERSE,
    S_SETTLE,
    S_FINISH
  } state_t;

  typedef enum logic {
    ZONE_LEFT  = 1'b0,
    ZONE_RIGHT = 1'b1
  } zone_t;

endpackage

// File: rtl/game_sprite_edge_detect.sv
// rtl/game_sprite_edge_detect.sv - combinational screen-edge hit and zone test for one axis
module game_sprite_edge_detect
  import game_launcher_pkg::*;
#(
  parameter int DX_WIDTH     = 2,
  parameter int screen_width = 640,
  parameter int sprite_width = 8,
  parameter int w_x          = $clog2(screen_width)
) (
  input  logic [w_x-1:0]      sprite_x_i,
  input  logic [DX_WIDTH-1:0] cur_dx_i,
  input  zone_t               zone_sel_i,
  output logic                hit_right_o,
  output logic                hit_left_o,
  output logic                in_zone_o
);

  logic in_right;
  logic in_left;
  logic moving_right;
  logic moving_left;

  // One extra bit keeps the compares correct when screen_width is a power of two.
  assign in_right     = ({1'b0, sprite_x_i} >= (w_x+1)'(screen_width - sprite_width));
  assign in_left      = (sprite_x_i == '0) || ({1'b0, sprite_x_i} >= (w_x+1)'(screen_width));
  assign moving_left  = cur_dx_i[DX_WIDTH-1];
  assign moving_right = !cur_dx_i[DX_WIDTH-1] && (cur_dx_i != '0);

  assign hit_right_o = moving_right && in_right;
  assign hit_left_o  = moving_left && in_left;
  assign in_zone_o   = (zone_sel_i == ZONE_RIGHT) ? in_right : in_left;

endmodule

// File: rtl/game_sprite_launcher.sv
// rtl/game_sprite_launcher.sv - launches a sprite, bounces it off the x edges, stops after max_bounces
module game_sprite_launcher
  import game_launcher_pkg::*;
#(
  parameter int DX_WIDTH      = 2,
  parameter int DY_WIDTH      = 2,
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int sprite_width  = 8,
  parameter int max_bounces   = 3,
  parameter int w_bounce      = (max_bounces > 0) ? $clog2(max_bounces + 1) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                launch_i,
  input  logic                abort_i,
  input  logic [w_x-1:0]      start_x_i,
  input  logic [w_y-1:0]      start_y_i,
  input  logic [DX_WIDTH-1:0] start_dx_i,
  input  logic [DY_WIDTH-1:0] start_dy_i,
  input  logic [w_x-1:0]      sprite_x_i,
  output logic                sprite_write_xy_o,
  output logic                sprite_write_dxy_o,
  output logic [w_x-1:0]      sprite_write_x_o,
  output logic [w_y-1:0]      sprite_write_y_o,
  output logic [DX_WIDTH-1:0] sprite_write_dx_o,
  output logic [DY_WIDTH-1:0] sprite_write_dy_o,
  output logic                sprite_enable_update_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [w_bounce-1:0] bounce_count_o
);

  localparam logic [w_bounce-1:0] MAX_B = w_bounce'(max_bounces);

  state_t              state_q, state_d;
  zone_t               zone_q, zone_d;
  logic [w_x-1:0]      x_q, x_d;
  logic [w_y-1:0]      y_q, y_d;
  logic [DX_WIDTH-1:0] dx_q, dx_d;
  logic [DY_WIDTH-1:0] dy_q, dy_d;
  logic [w_bounce-1:0] bounce_q, bounce_d;
  logic                write_xy_q, write_xy_d;
  logic                write_dxy_q, write_dxy_d;
  logic                enable_q, enable_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                hit_right, hit_left, in_zone;

  game_sprite_edge_detect #(
    .DX_WIDTH    (DX_WIDTH),
    .screen_width(screen_width),
    .sprite_width(sprite_width),
    .w_x         (w_x)
  ) u_edge (
    .sprite_x_i (sprite_x_i),
    .cur_dx_i   (dx_q),
    .zone_sel_i (zone_q),
    .hit_right_o(hit_right),
    .hit_left_o (hit_left),
    .in_zone_o  (in_zone)
  );

  always_comb begin
    state_d  = state_q;
    zone_d   = zone_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    bounce_d = bounce_q;
    case (state_q)
      S_IDLE: begin
        if (launch_i && !abort_i) begin
          state_d  = S_LOAD_XY;
          x_d      = start_x_i;
          y_d      = start_y_i;
          dx_d     = start_dx_i;
          dy_d     = start_dy_i;
          bounce_d = '0;
        end
      end
      S_LOAD_XY:  state_d = S_LOAD_DXY;
      S_LOAD_DXY: state_d = S_RUN;
      S_RUN: begin
        if (hit_right || hit_left) begin
          zone_d = hit_right ? ZONE_RIGHT : ZONE_LEFT;
          if (bounce_q == MAX_B) begin
            state_d = S_FINISH;
          end else begin
            // Reversal happens on entry so the new dx is on the outputs during REVERSE.
            state_d  = S_REVERSE;
            dx_d     = -dx_q;
            bounce_d = bounce_q + w_bounce'(1);
          end
        end
      end
      S_REVERSE: state_d = S_SETTLE;
      S_SETTLE:  if (!in_zone) state_d = S_RUN;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (abort_i && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      zone_d   = zone_q;
      dx_d     = dx_q;
      bounce_d = bounce_q;
    end
    write_xy_d  = (state_d == S_LOAD_XY);
    write_dxy_d = (state_d == S_LOAD_DXY) || (state_d == S_REVERSE);
    enable_d    = (state_d == S_RUN) || (state_d == S_SETTLE);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      zone_q      <= ZONE_LEFT;
      x_q         <= '0;
      y_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      bounce_q    <= '0;
      write_xy_q  <= 1'b0;
      write_dxy_q <= 1'b0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      zone_q      <= zone_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      bounce_q    <= bounce_d;
      write_xy_q  <= write_xy_d;
      write_dxy_q <= write_dxy_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign sprite_write_xy_o      = write_xy_q;
  assign sprite_write_dxy_o     = write_dxy_q;
  assign sprite_write_x_o       = x_q;
  assign sprite_write_y_o       = y_q;
  assign sprite_write_dx_o      = dx_q;
  assign sprite_write_dy_o      = dy_q;
  assign sprite_enable_update_o = enable_q;
  assign busy_o                 = busy_q;
  assign done_o                 = done_q;
  assign bounce_count_o         = bounce_q;

endmodule

// File: tb/tb_game_sprite_launcher.sv
// tb/tb_game_sprite_launcher.sv - scoreboard bench for game_sprite_launcher with a sprite-control model
module tb_game_sprite_launcher;

  localparam int W_X = 10;
  localparam int W_Y = 9;
  localparam logic [1:0] EV_XY   = 2'd0;
  localparam logic [1:0] EV_DXY  = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]     kind;
    logic [W_X-1:0] a;
    logic [W_Y-1:0] b;
    logic [1:0]     bc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           launch_i, abort_i;
  logic [W_X-1:0] start_x_i, sprite_x_i;
  logic [W_Y-1:0] start_y_i;
  logic [1:0]     start_dx_i, start_dy_i;
  logic           wxy, wdxy, enable, busy, done;
  logic [W_X-1:0] wx;
  logic [W_Y-1:0] wy;
  logic [1:0]     wdx, wdy, bc;

  game_sprite_launcher dut (
    .clk                   (clk),
    .rst                   (rst),
    .launch_i              (launch_i),
    .abort_i               (abort_i),
    .start_x_i             (start_x_i),
    .start_y_i             (start_y_i),
    .start_dx_i            (start_dx_i),
    .start_dy_i            (start_dy_i),
    .sprite_x_i            (sprite_x_i),
    .sprite_write_xy_o     (wxy),
    .sprite_write_dxy_o    (wdxy),
    .sprite_write_x_o      (wx),
    .sprite_write_y_o      (wy),
    .sprite_write_dx_o     (wdx),
    .sprite_write_dy_o     (wdy),
    .sprite_enable_update_o(enable),
    .busy_o                (busy),
    .done_o                (done),
    .bounce_count_o        (bc)
  );

  // Sprite control stand-in: x steps by signed dx every second cycle while enabled.
  logic [1:0] spr_dx;
  logic       tick;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sprite_x_i <= '0;
      spr_dx     <= '0;
      tick       <= 1'b0;
    end else begin
      tick <= ~tick;
      if (wxy) sprite_x_i <= wx;
      else if (enable && tick) sprite_x_i <= sprite_x_i + {{(W_X-2){spr_dx[1]}}, spr_dx};
      if (wdxy) spr_dx <= wdx;
    end
  end

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic [1:0] k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k;
    e.a    = W_X'(a);
    e.b    = W_Y'(b);
    e.bc   = 2'(c);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    ev_t act;
    ev_t exp;
    if (!rst && (wxy || wdxy || done)) begin
      check("one_strobe", 32'(wxy) + 32'(wdxy) + 32'(done), 32'd1);
      if (wxy)       act = mk(EV_XY, int'(wx), int'(wy), int'(bc));
      else if (wdxy) act = mk(EV_DXY, int'(wdx), int'(wdy), int'(bc));
      else           act = mk(EV_DONE, 0, 0, int'(bc));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=0x%0h expected=none", act);
      end else begin
        exp = exp_q.pop_front();
        check("event", 32'(act), 32'(exp));
      end
    end
  end

  task automatic do_launch(input int x, input int y, input int dx, input int dy);
    @(negedge clk);
    start_x_i  = W_X'(x);
    start_y_i  = W_Y'(y);
    start_dx_i = 2'(dx);
    start_dy_i = 2'(dy);
    launch_i   = 1'b1;
    @(negedge clk);
    launch_i   = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({wxy, wdxy, wx, wy, wdx, wdy, enable, busy, done, bc});
  endfunction

  initial begin
    bit found;
    launch_i = 0; abort_i = 0;
    start_x_i = '0; start_y_i = '0; start_dx_i = '0; start_dy_i = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Latency, then abort in RUN and launch+abort in IDLE.
    exp_q.push_back(mk(EV_XY, 100, 50, 0));
    exp_q.push_back(mk(EV_DXY, 1, 1, 0));
    do_launch(100, 50, 1, 1);
    check("c1_write_xy", 32'(wxy), 32'd1);
    check("c1_busy", 32'(busy), 32'd1);
    check("c1_enable", 32'(enable), 32'd0);
    @(negedge clk);
    check("c2_write_dxy", 32'(wdxy), 32'd1);
    check("c2_enable", 32'(enable), 32'd0);
    @(negedge clk);
    check("c3_enable", 32'(enable), 32'd1);
    repeat (5) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    check("abort_enable", 32'(enable), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    launch_i  = 1'b1;
    start_x_i = 10'd7;
    @(negedge clk);
    check("launch_abort_busy", 32'(busy), 32'd0);
    launch_i = 1'b0;
    abort_i  = 1'b0;
    repeat (3) @(negedge clk);

    // Three bounces then FINISH on the fourth edge; a mid-run launch must be ignored.
    exp_q.push_back(mk(EV_XY, 630, 7, 0));
    exp_q.push_back(mk(EV_DXY, 1, 3, 0));
    exp_q.push_back(mk(EV_DXY, 3, 3, 1));
    exp_q.push_back(mk(EV_DXY, 1, 3, 2));
    exp_q.push_back(mk(EV_DXY, 3, 3, 3));
    exp_q.push_back(mk(EV_DONE, 0, 0, 3));
    do_launch(630, 7, 1, 3);
    repeat (20) @(negedge clk);
    start_x_i = 10'd5;
    launch_i  = 1'b1;
    @(negedge clk);
    launch_i = 1'b0;
    found = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    check("done_seen", 32'(found), 32'd1);
    check("finish_enable", 32'(enable), 32'd0);
    check("finish_bounce", 32'(bc), 32'd3);
    @(negedge clk);
    check("post_done_busy", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);

    // Asynchronous reset while in SETTLE.
    exp_q.push_back(mk(EV_XY, 620, 9, 0));
    exp_q.push_back(mk(EV_DXY, 1, 0, 0));
    exp_q.push_back(mk(EV_DXY, 3, 0, 1));
    do_launch(620, 9, 1, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (wdxy && bc == 2'd1) found = 1;
    end
    check("reverse_seen", 32'(found), 32'd1);
    @(negedge clk);
    check("settle_enable", 32'(enable), 32'd1);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("queue_after_rst", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    // dx == 0 inside the right zone never bounces.
    exp_q.push_back(mk(EV_XY, 635, 1, 0));
    exp_q.push_back(mk(EV_DXY, 0, 1, 0));
    do_launch(635, 1, 0, 1);
    repeat (3000) @(negedge clk);
    check("dx0_busy", 32'(busy), 32'd1);
    check("dx0_enable", 32'(enable), 32'd1);
    check("dx0_bounce", 32'(bc), 32'd0);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("dx0_abort_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
